// File: rtl/sfft_pkg.sv
// Shared definitions for the half-size sub-FFT interconnect and butterfly stages.
package sfft_pkg;

  typedef enum logic {
    S_FILL_EVEN = 1'b0,
    S_PAIR      = 1'b1
  } sfft_state_e;

  localparam int unsigned SFFT_SIZE_BUFFER_DEF   = 1;
  localparam int unsigned SFFT_DATA_FFT_SIZE_DEF = 16;

  function automatic int unsigned sfft_nfft(input int unsigned size_buffer);
    return 32'd1 << size_buffer;
  endfunction

  function automatic int unsigned sfft_half_depth(input int unsigned size_buffer);
    return sfft_nfft(size_buffer) >> 1;
  endfunction

  // A depth-1 half buffer still needs a 1-bit address to stay a legal array index.
  function automatic int unsigned sfft_buf_addr_w(input int unsigned size_buffer);
    return (size_buffer > 1) ? size_buffer - 1 : 1;
  endfunction

endpackage

// File: rtl/sfft_half_buffer.sv
// Even-half result store: synchronous write, combinational read so the read data
// can be captured in the same output register as the matching odd sample.
module sfft_half_buffer #(
  parameter int unsigned ADDR_W = 1,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/interconnect_sfft_to_butterfly.sv
// Pairs the even-half and odd-half results of the shared sub-FFT and hands
// {E[k], O[k], k} to the final radix-2 butterfly through a single-entry register.
//
//   state       | meaning
//   S_FILL_EVEN | storing E[0..NFFT/2-1] into the half buffer
//   S_PAIR      | each accepted O[k] is joined with buffered E[k] and presented
module interconnect_sfft_to_butterfly
  import sfft_pkg::*;
#(
  parameter int unsigned SIZE_BUFFER   = SFFT_SIZE_BUFFER_DEF,
  parameter int unsigned DATA_FFT_SIZE = SFFT_DATA_FFT_SIZE_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [DATA_FFT_SIZE-1:0] i_in_data_i,
  input  logic [DATA_FFT_SIZE-1:0] i_in_data_q,
  input  logic                     i_valid,
  output logic                     o_wayt_data,
  output logic [DATA_FFT_SIZE-1:0] o_even_i,
  output logic [DATA_FFT_SIZE-1:0] o_even_q,
  output logic [DATA_FFT_SIZE-1:0] o_odd_i,
  output logic [DATA_FFT_SIZE-1:0] o_odd_q,
  output logic [SIZE_BUFFER-1:0]   o_index,
  output logic                     o_outvalid,
  output logic                     o_last,
  input  logic                     i_butterfly_ready
);

  localparam int unsigned LP_HALF   = sfft_half_depth(SIZE_BUFFER);
  localparam int unsigned LP_ADDR_W = sfft_buf_addr_w(SIZE_BUFFER);
  localparam logic [SIZE_BUFFER-1:0] LP_LAST = SIZE_BUFFER'(LP_HALF - 1);

  sfft_state_e                r_state;
  sfft_state_e                w_state_nxt;
  logic [SIZE_BUFFER-1:0]     r_counter;
  logic                       w_accept;
  logic                       w_cnt_last;
  logic                       w_wr_en;
  logic                       w_load;
  logic [LP_ADDR_W-1:0]       w_addr;
  logic [2*DATA_FFT_SIZE-1:0] w_rd_data;

  assign w_accept   = i_valid & o_wayt_data;
  assign w_cnt_last = (r_counter == LP_LAST);
  assign w_wr_en    = w_accept & (r_state == S_FILL_EVEN);
  assign w_load     = w_accept & (r_state == S_PAIR);
  assign w_addr     = r_counter[LP_ADDR_W-1:0];

  sfft_half_buffer #(
    .ADDR_W (LP_ADDR_W),
    .DATA_W (2*DATA_FFT_SIZE)
  ) u_half_buffer (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_addr),
    .i_wr_data ({i_in_data_i, i_in_data_q}),
    .i_rd_addr (w_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_FILL_EVEN;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL_EVEN: if (w_accept && w_cnt_last) w_state_nxt = S_PAIR;
      S_PAIR:      if (w_accept && w_cnt_last) w_state_nxt = S_FILL_EVEN;
      default:     w_state_nxt = S_FILL_EVEN;
    endcase
  end

  // Only pairing can be back-pressured; even samples never touch the output register.
  always_comb begin
    o_wayt_data = 1'b1;
    if (r_state == S_PAIR) o_wayt_data = !o_outvalid | i_butterfly_ready;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_counter <= '0;
    end else if (w_accept) begin
      r_counter <= w_cnt_last ? '0 : r_counter + SIZE_BUFFER'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_even_i   <= '0;
      o_even_q   <= '0;
      o_odd_i    <= '0;
      o_odd_q    <= '0;
      o_index    <= '0;
      o_outvalid <= 1'b0;
      o_last     <= 1'b0;
    end else if (w_load) begin
      o_even_i   <= w_rd_data[2*DATA_FFT_SIZE-1:DATA_FFT_SIZE];
      o_even_q   <= w_rd_data[DATA_FFT_SIZE-1:0];
      o_odd_i    <= i_in_data_i;
      o_odd_q    <= i_in_data_q;
      o_index    <= r_counter;
      o_outvalid <= 1'b1;
      o_last     <= w_cnt_last;
    end else if (i_butterfly_ready) begin
      o_outvalid <= 1'b0;
      o_last     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interconnect_sfft_to_butterfly.sv
// Scoreboard bench: a frame-level model predicts pairs at stimulus time,
// a monitor compares whatever the DUT presents against the queue head.
module tb_interconnect_sfft_to_butterfly;

  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] ei, eq, oi, oq;
    int            k;
    bit            last;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_i, in_q;
  logic          valid, ready, sel;
  logic          v3, v1;

  logic          w3, ov3, last3, w1, ov1, last1;
  logic [DW-1:0] ei3, eq3, oi3, oq3, ei1, eq1, oi1, oq1;
  logic [2:0]    idx3;
  logic [0:0]    idx1;

  logic          obs_w, obs_ov, obs_last;
  logic [DW-1:0] obs_ei, obs_eq, obs_oi, obs_oq;
  logic [2:0]    obs_idx;

  pair_t         q[$];
  logic [DW-1:0] ev_i[4], ev_q[4];
  int            pos, half, rdy_mode;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  assign v3 = valid & ~sel;
  assign v1 = valid & sel;

  interconnect_sfft_to_butterfly #(.SIZE_BUFFER(3), .DATA_FFT_SIZE(DW)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_in_data_i(in_i), .i_in_data_q(in_q),
    .i_valid(v3), .o_wayt_data(w3), .o_even_i(ei3), .o_even_q(eq3),
    .o_odd_i(oi3), .o_odd_q(oq3), .o_index(idx3), .o_outvalid(ov3),
    .o_last(last3), .i_butterfly_ready(ready)
  );

  interconnect_sfft_to_butterfly #(.SIZE_BUFFER(1), .DATA_FFT_SIZE(DW)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_in_data_i(in_i), .i_in_data_q(in_q),
    .i_valid(v1), .o_wayt_data(w1), .o_even_i(ei1), .o_even_q(eq1),
    .o_odd_i(oi1), .o_odd_q(oq1), .o_index(idx1), .o_outvalid(ov1),
    .o_last(last1), .i_butterfly_ready(ready)
  );

  always_comb begin
    if (sel) begin
      obs_w = w1; obs_ov = ov1; obs_last = last1; obs_idx = {2'b00, idx1};
      obs_ei = ei1; obs_eq = eq1; obs_oi = oi1; obs_oq = oq1;
    end else begin
      obs_w = w3; obs_ov = ov3; obs_last = last3; obs_idx = idx3;
      obs_ei = ei3; obs_eq = eq3; obs_oi = oi3; obs_oq = oq3;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame model: first half of a frame is E[k], second half O[k] paired with E[k].
  task automatic record(input logic [DW-1:0] di, input logic [DW-1:0] dq);
    pair_t p;
    if (pos < half) begin
      ev_i[pos] = di;
      ev_q[pos] = dq;
    end else begin
      p.k = pos - half;
      p.ei = ev_i[p.k]; p.eq = ev_q[p.k];
      p.oi = di;        p.oq = dq;
      p.last = (p.k == half - 1);
      q.push_back(p);
    end
    pos++;
    if (pos == 2*half) pos = 0;
  endtask

  // Called and returns at a falling edge.
  task automatic send(input logic [DW-1:0] di, input logic [DW-1:0] dq, input int gap);
    int  budget;
    bit  done;
    logic exp_w;
    for (int g = 0; g < gap; g++) begin
      valid = 1'b0;
      @(negedge clk);
    end
    valid = 1'b1; in_i = di; in_q = dq;
    budget = 0; done = 1'b0;
    while (!done) begin
      #1;
      exp_w = (pos < half) || (q.size() == 0) || ready;
      chk("wayt_data", 64'(obs_w), 64'(exp_w));
      if (obs_w) done = 1'b1;
      @(posedge clk);
      if (done) record(di, dq);
      @(negedge clk);
      budget++;
      if (!done && budget > 200) begin
        chk("send_timeout", 64'(budget), 64'(0));
        done = 1'b1;
      end
    end
    valid = 1'b0;
  endtask

  task automatic send_v(input int v, input int gap);
    send(DW'(v), DW'(-v), gap);
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    pos = 0;
    #1;
    chk("reset_outvalid_async", 64'(obs_ov), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_outvalid", 64'(obs_ov), 64'(0));
    chk("rst_last", 64'(obs_last), 64'(0));
    chk("rst_index", 64'(obs_idx), 64'(0));
    chk("rst_data", {obs_ei, obs_eq, obs_oi, obs_oq}, 64'(0));
    chk("rst_wayt", 64'(obs_w), 64'(1));
  endtask

  task automatic stall_script();
    int n;
    n = 0;
    while (!obs_ov && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("stall_wait_timeout", 64'(n), 64'(0));
    ready = 1'b0;
    repeat (3) @(negedge clk);
    ready = 1'b1;
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  end

  // Monitor: o_outvalid must track the model's pending-pair count; the head pair
  // is compared every cycle it is shown and retired on handshake.
  always @(negedge clk) begin
    #2;
    chk("outvalid", 64'(obs_ov), 64'(q.size() > 0));
    if (obs_ov && q.size() > 0) begin
      chk("pair_data", {obs_ei, obs_eq, obs_oi, obs_oq}, {q[0].ei, q[0].eq, q[0].oi, q[0].oq});
      chk("pair_index", 64'(obs_idx), 64'(q[0].k));
      chk("pair_last", 64'(obs_last), 64'(q[0].last));
      if (ready) void'(q.pop_front());
    end
  end

  initial begin
    valid = 1'b0; in_i = '0; in_q = '0; sel = 1'b0; ready = 1'b1;
    rdy_mode = 0; half = 4; pos = 0;
    do_reset();
    check_reset_vals();

    for (int v = 1; v <= 8; v++) send_v(v, 0);
    idle(3);

    rdy_mode = 2; ready = 1'b1;
    fork
      for (int v = 1; v <= 8; v++) send_v(v, 0);
      stall_script();
    join
    rdy_mode = 0;
    idle(3);

    for (int v = 1; v <= 16; v++) send_v(v, 0);
    idle(3);

    for (int v = 1; v <= 8; v++) send_v(v, 1);
    idle(3);

    for (int v = 1; v <= 6; v++) send_v(v, 0);
    do_reset();
    for (int v = 20; v <= 27; v++) send_v(v, 0);
    idle(3);

    sel = 1'b1; half = 1;
    do_reset();
    check_reset_vals();
    send(16'h000A, 16'h00A0, 0);
    send(16'h000B, 16'h00B0, 0);
    send(16'h000C, 16'h00C0, 0);
    send(16'h000D, 16'h00D0, 0);
    idle(3);

    rdy_mode = 1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      half = (s == 0) ? 4 : 1;
      do_reset();
      for (int n = 0; n < 6 * 2 * half; n++)
        send(DW'($urandom), DW'($urandom), $urandom_range(0, 2));
      idle(2);
    end
    rdy_mode = 0;
    idle(6);
    chk("scoreboard_empty", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
